anc_coef_ram_sched: RTL and testbench

//  Controller for the 256x11 ANC coefficient block RAM (single port, 1-cycle registered read).

---
 rtl/anc_pkg.sv | 22 ++
 rtl/anc_tap_addr_gen.sv | 51 +++++
 rtl/anc_coef_ram_sched.sv | 146 ++++++++++++++
 tb/tb_anc_coef_ram_sched.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anc_pkg.sv
// Shared constants, FSM state type and window helper for the ANC coefficient RAM scheduler.
package anc_pkg;

    localparam int ANC_ADDR_W = 8;
    localparam int ANC_DATA_W = 11;
    localparam int ANC_N_TAPS = 12;
    localparam int ANC_BASE0  = 52;
    localparam int ANC_BASE1  = 116;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE
    } state_t;

    // True when addr falls inside the tap window starting at base.
    function automatic logic in_window(input int addr, input int base, input int n_taps);
        return (addr >= base) && (addr < base + n_taps);
    endfunction

endpackage

// File: rtl/anc_tap_addr_gen.sv
// Tap counter and read-address generator; delays valid/idx/last by one cycle so they line up
// with the registered RAM read data.
module anc_tap_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int N_TAPS = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              clear,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] tap_addr,
    output logic              issue_last,
    output logic              coef_valid,
    output logic [3:0]        coef_idx,
    output logic              coef_last
);

    localparam logic [3:0] K_LAST = 4'(N_TAPS - 1);

    logic [3:0] k;
    logic [3:0] iss_idx;
    logic       iss_v;

    // Taps are streamed from the top of the window downwards.
    assign tap_addr = base + ADDR_W'(N_TAPS - 1) - ADDR_W'(k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k          <= '0;
            iss_v      <= 1'b0;
            iss_idx    <= '0;
            issue_last <= 1'b0;
            coef_valid <= 1'b0;
            coef_idx   <= '0;
            coef_last  <= 1'b0;
        end else begin
            if (issue)      k <= k + 4'd1;
            else if (clear) k <= '0;

            iss_v      <= issue;
            iss_idx    <= k;
            issue_last <= issue && (k == K_LAST);

            coef_valid <= iss_v;
            coef_idx   <= iss_idx;
            coef_last  <= issue_last;
        end
    end

endmodule

// File: rtl/anc_coef_ram_sched.sv
// Single-port coefficient RAM arbiter: per-sample tap read passes for the MAC, loader writes
// into the shadow bank, and bank swaps deferred to pass boundaries.
module anc_coef_ram_sched
    import anc_pkg::*;
#(
    parameter int ADDR_W = ANC_ADDR_W,
    parameter int DATA_W = ANC_DATA_W,
    parameter int N_TAPS = ANC_N_TAPS,
    parameter int BASE0  = ANC_BASE0,
    parameter int BASE1  = ANC_BASE1
) (
    input  logic              Clk_100M,
    input  logic              Reset_n,
    input  logic              sample_valid,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    output logic              ld_err,
    input  logic              swap_req,
    input  logic              overrun_clr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              coef_valid,
    output logic [DATA_W-1:0] coef_data,
    output logic [3:0]        coef_idx,
    output logic              coef_last,
    output logic              active_bank,
    output logic              busy,
    output logic              overrun
);

    localparam bit WINDOWS_FIT = (N_TAPS >= 1) && (N_TAPS <= 16) &&
                                 (BASE0 + N_TAPS <= 2 ** ADDR_W) &&
                                 (BASE1 + N_TAPS <= 2 ** ADDR_W);

    state_t            state;
    logic              sample_q;
    logic              swap_pending;
    logic              pass_busy;
    logic              swap_now;
    logic              issue;
    logic              issue_last;
    logic              ld_hit;
    logic [ADDR_W-1:0] bank_base;
    logic [ADDR_W-1:0] tap_addr;

    // sample_q marks the start cycle: a sample is accepted but the pass has not begun yet.
    assign pass_busy = (state == READ) || (state == DRAIN) || sample_q;
    assign bank_base = active_bank ? ADDR_W'(BASE1) : ADDR_W'(BASE0);
    assign ld_hit    = in_window(int'(ld_addr), active_bank ? BASE1 : BASE0, N_TAPS);
    assign swap_now  = (state == IDLE) && !sample_q && !sample_valid && (swap_pending || swap_req);
    assign issue     = ((state == IDLE) && sample_q) || ((state == READ) && !issue_last);
    assign coef_data = ram_dout;

    anc_tap_addr_gen #(
        .ADDR_W (ADDR_W),
        .N_TAPS (N_TAPS)
    ) u_tap_gen (
        .clk        (Clk_100M),
        .rst_n      (Reset_n),
        .issue      (issue),
        .clear      (state != READ),
        .base       (bank_base),
        .tap_addr   (tap_addr),
        .issue_last (issue_last),
        .coef_valid (coef_valid),
        .coef_idx   (coef_idx),
        .coef_last  (coef_last)
    );

    always_ff @(posedge Clk_100M or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            sample_q     <= 1'b0;
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            ld_ack       <= 1'b0;
            ld_err       <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
        end else begin
            // NOTE: strobes default low each cycle so every branch below only states when they fire.
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ld_ack   <= 1'b0;
            ld_err   <= 1'b0;
            sample_q <= sample_valid && !pass_busy;

            if (sample_valid && pass_busy) overrun <= 1'b1;
            else if (overrun_clr)          overrun <= 1'b0;

            if (swap_now) begin
                active_bank  <= !active_bank;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (sample_q) begin
                        state    <= READ;
                        busy     <= 1'b1;
                        ram_en   <= 1'b1;
                        ram_addr <= tap_addr;
                    end else if (ld_req && !sample_valid && !swap_now) begin
                        // A write into the live window is acknowledged but never reaches the RAM.
                        state    <= WRITE;
                        ld_ack   <= 1'b1;
                        ld_err   <= ld_hit;
                        ram_en   <= !ld_hit;
                        ram_we   <= !ld_hit;
                        ram_addr <= ld_addr;
                        ram_din  <= ld_data;
                    end
                end
                READ: begin
                    if (issue_last) begin
                        state <= DRAIN;
                    end else begin
                        ram_en   <= 1'b1;
                        ram_addr <= tap_addr;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                WRITE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    window_fit_a: assert property (@(posedge Clk_100M) WINDOWS_FIT)
        else $error("tap window does not fit in the RAM address space");

endmodule

// File: tb/tb_anc_coef_ram_sched.sv
// Scoreboard bench: stimulus pushes expected taps/acks computed from a reference coefficient
// memory and bank state; a negedge monitor pops and compares whenever the DUT presents them.
module tb_anc_coef_ram_sched;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 11;
    localparam int N_TAPS = 12;
    localparam int BASE0  = 52;
    localparam int BASE1  = 116;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [3:0]        idx;
        logic              last;
    } coef_t;

    logic              clk = 1'b0;
    logic              Reset_n;
    logic              sample_valid, ld_req, swap_req, overrun_clr;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ack, ld_err, ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout, coef_data;
    logic              coef_valid, coef_last, active_bank, busy, overrun;
    logic [3:0]        coef_idx;

    int    n_checks = 0;
    int    n_fail   = 0;
    coef_t exp_coef[$];
    bit    exp_err[$];
    int    ref_mem[256];
    int    ref_bank;
    logic [DATA_W-1:0] mem[256];

    always #5 clk = ~clk;

    anc_coef_ram_sched #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_TAPS(N_TAPS), .BASE0(BASE0), .BASE1(BASE1)
    ) dut (
        .Clk_100M(clk), .Reset_n(Reset_n), .sample_valid(sample_valid),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack), .ld_err(ld_err),
        .swap_req(swap_req), .overrun_clr(overrun_clr),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_idx(coef_idx), .coef_last(coef_last),
        .active_bank(active_bank), .busy(busy), .overrun(overrun)
    );

    // Behavioural single-port RAM with a one-cycle registered read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input int a, input int bank);
        int b;
        b = bank ? BASE1 : BASE0;
        return (a >= b) && (a < b + N_TAPS);
    endfunction

    // Monitor: compares every presented coefficient and acknowledge against the scoreboard.
    always @(negedge clk) begin
        coef_t e;
        bit    ee;
        if (Reset_n) begin
            if (coef_valid) begin
                if (exp_coef.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL coef_extra: got coef idx %0d while no tap expected at %0t", coef_idx, $time);
                end else begin
                    e = exp_coef.pop_front();
                    check("coef_data", 32'(coef_data), 32'(e.data));
                    check("coef_idx", 32'(coef_idx), 32'(e.idx));
                    check("coef_last", 32'(coef_last), 32'(e.last));
                end
            end
            if (ld_ack) begin
                if (exp_err.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ack_extra: got ld_ack with no request pending at %0t", $time);
                end else begin
                    ee = exp_err.pop_front();
                    check("ld_err", 32'(ld_err), 32'(ee));
                end
            end
            if (ram_en && ram_we) check("write_not_busy", 32'(busy), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a sample (held for 'hold' cycles) and queue the taps of the bank that should serve it.
    task automatic start_pass(input int hold, input bit with_swap);
        coef_t e;
        int    b;
        b = ref_bank ? BASE1 : BASE0;
        for (int k = 0; k < N_TAPS; k++) begin
            e.data = DATA_W'(ref_mem[b + N_TAPS - 1 - k]);
            e.idx  = 4'(k);
            e.last = (k == N_TAPS - 1);
            exp_coef.push_back(e);
        end
        sample_valid = 1'b1;
        swap_req     = with_swap;
        tick();
        swap_req     = 1'b0;
        for (int i = 1; i < hold; i++) tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!busy && exp_coef.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("pass_done", 32'(done), 1);
    endtask

    task automatic do_write(input int addr, input int data, output int waited);
        bit err, got;
        err = in_win(addr, ref_bank);
        exp_err.push_back(err);
        if (!err) ref_mem[addr] = data;
        ld_addr = ADDR_W'(addr);
        ld_data = DATA_W'(data);
        ld_req  = 1'b1;
        got     = 1'b0;
        waited  = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            waited++;
            if (ld_ack) begin
                got = 1'b1;
                break;
            end
        end
        ld_req = 1'b0;
        check("ld_ack_seen", 32'(got), 1);
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        ref_bank ^= 1;
        check("swap_bank", 32'(active_bank), 32'(ref_bank));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        Reset_n = 1'b0; sample_valid = 1'b0; ld_req = 1'b0; swap_req = 1'b0; overrun_clr = 1'b0;
        ld_addr = '0; ld_data = '0; ram_dout = '0; ref_bank = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = 0;
        end
        repeat (3) tick();
        check("rst_ram_en", 32'(ram_en), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ld_ack", 32'(ld_ack), 0);
        check("rst_coef_valid", 32'(coef_valid), 0);
        check("rst_active_bank", 32'(active_bank), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        Reset_n = 1'b1;
        tick();

        // Preload bank 0 (63..52 = 1..12), then one pass with latency checks.
        for (int j = 0; j < N_TAPS; j++) do_write(BASE0 + N_TAPS - 1 - j, j + 1, w);
        tick();
        start_pass(1, 1'b0);
        check("start_cycle_busy", 32'(busy), 0);
        check("start_cycle_valid", 32'(coef_valid), 0);
        tick();
        check("first_busy", 32'(busy), 1);
        check("first_ram_en", 32'(ram_en), 1);
        check("first_ram_addr", 32'(ram_addr), 63);
        tick();
        check("first_coef_valid", 32'(coef_valid), 1);
        wait_idle();
        check("busy_after_pass", 32'(busy), 0);

        // Shadow write accepted, active-window write rejected and RAM left untouched.
        do_write(120, 5, w);
        tick();
        check("ram_120_written", 32'(mem[120]), 5);
        do_write(60, int'($urandom_range(100, 2047)), w);
        tick();
        check("ram_60_kept", 32'(mem[60]), 32'(ref_mem[60]));

        // Fill bank 1 with 12..1, swap, and stream it.
        for (int j = 0; j < N_TAPS; j++) do_write(BASE1 + N_TAPS - 1 - j, N_TAPS - j, w);
        tick();
        do_swap();
        start_pass(1, 1'b0);
        wait_idle();

        // Loader request mid-pass must wait for the pass to finish.
        start_pass(1, 1'b0);
        repeat (2) tick();
        do_write(BASE0 + int'($urandom_range(0, N_TAPS - 1)), int'($urandom_range(0, 2047)), w);
        check("ack_after_pass", 32'(busy), 0);
        check("ld_stalled", 32'(w > N_TAPS), 1);
        tick();

        // Swap coincident with a sample: old bank serves the pass; a second request is ignored.
        start_pass(1, 1'b1);
        repeat (3) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("bank_held_in_pass", 32'(active_bank), 32'(ref_bank));
        wait_idle();
        check("bank_held_to_end", 32'(active_bank), 32'(ref_bank));
        tick();
        ref_bank ^= 1;
        check("bank_swapped_after", 32'(active_bank), 32'(ref_bank));
        repeat (3) tick();
        check("second_swap_ignored", 32'(active_bank), 32'(ref_bank));

        // Randomised mix of writes, swaps and passes against the reference memory.
        for (int it = 0; it < 40; it++) begin
            int op, a;
            op = int'($urandom_range(0, 4));
            if (op <= 1) begin
                case ($urandom_range(0, 2))
                    0:       a = BASE0 + int'($urandom_range(0, N_TAPS - 1));
                    1:       a = BASE1 + int'($urandom_range(0, N_TAPS - 1));
                    default: a = int'($urandom_range(0, 255));
                endcase
                do_write(a, int'($urandom_range(0, 2047)), w);
                tick();
            end else if (op == 2) begin
                do_swap();
            end else begin
                start_pass(1, 1'b0);
                wait_idle();
            end
        end

        // Second sample at tap 5: overrun set, no extra pass; then clear it.
        start_pass(1, 1'b0);
        repeat (6) tick();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("overrun_set", 32'(overrun), 1);
        wait_idle();
        repeat (N_TAPS + 4) tick();
        check("no_extra_pass", 32'(busy), 0);
        check("overrun_sticky", 32'(overrun), 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("overrun_cleared", 32'(overrun), 0);

        // Sample held into the start cycle also counts as overrun.
        start_pass(2, 1'b0);
        wait_idle();
        check("overrun_start_cycle", 32'(overrun), 1);

        // Reset in the middle of a bank-1 pass.
        if (ref_bank == 0) do_swap();
        start_pass(1, 1'b0);
        repeat (5) tick();
        Reset_n = 1'b0;
        exp_coef.delete();
        ref_bank = 0;
        #1;
        check("midrst_coef_valid", 32'(coef_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ram_en", 32'(ram_en), 0);
        check("midrst_active_bank", 32'(active_bank), 0);
        check("midrst_overrun", 32'(overrun), 0);
        repeat (2) tick();
        Reset_n = 1'b1;
        tick();
        start_pass(1, 1'b0);
        wait_idle();
        check("tap_queue_empty", 32'(exp_coef.size()), 0);
        check("ack_queue_empty", 32'(exp_err.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
